// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer: latches one decoded ALU op with forwarding, holds the
// ALU inputs steady while it is busy, and parks the result in a valid/ready writeback register.
module alu_exec_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 i_clk_n,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  output logic                 o_id_ready,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic [XLEN-1:0]      i_id_rs1_data,
  input  logic [XLEN-1:0]      i_id_rs2_data,
  input  logic [XLEN-1:0]      i_id_imm,
  input  logic                 i_id_use_imm,
  input  logic [2:0]           i_id_funct3,
  input  logic [6:0]           i_id_funct7,
  input  logic [REG_IDX_W-1:0] i_id_rd,
  output logic [XLEN-1:0]      o_alu_in_a,
  output logic [XLEN-1:0]      o_alu_in_b,
  output logic [2:0]           o_alu_funct3,
  output logic [6:0]           o_alu_funct7,
  output logic                 o_alu_en,
  output logic                 o_alu_imm,
  input  logic                 i_alu_busy,
  input  logic [XLEN-1:0]      i_alu_out,
  output logic                 o_wb_valid,
  input  logic                 i_wb_ready,
  output logic [XLEN-1:0]      o_wb_data,
  output logic [REG_IDX_W-1:0] o_wb_rd
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   fwd_valid;
  logic [REG_IDX_W-1:0]   rd;
  logic [XLEN-1:0]        fwd_a, fwd_b;

  assign o_id_ready = (state == IDLE) | ((state == DONE) & i_wb_ready);
  assign accept     = i_id_valid & o_id_ready;
  assign o_alu_en   = (state == EXEC);

  // x0 is hardwired, so a stale result tagged rd=0 must never be forwarded
  assign fwd_a = (fwd_valid && i_id_rs1 == o_wb_rd && i_id_rs1 != '0) ? o_wb_data : i_id_rs1_data;
  assign fwd_b = (fwd_valid && i_id_rs2 == o_wb_rd && i_id_rs2 != '0) ? o_wb_data : i_id_rs2_data;

  always_ff @(posedge i_clk_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (!i_alu_busy) state_nxt = DONE;
      DONE:    if (i_wb_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_n) begin
    if (!i_rst_n) begin
      o_alu_in_a   <= '0;
      o_alu_in_b   <= '0;
      o_alu_funct3 <= '0;
      o_alu_funct7 <= '0;
      o_alu_imm    <= 1'b0;
      rd           <= '0;
      o_wb_valid   <= 1'b0;
      o_wb_data    <= '0;
      o_wb_rd      <= '0;
      fwd_valid    <= 1'b0;
    end else begin
      if (accept) begin
        o_alu_in_a   <= fwd_a;
        o_alu_in_b   <= i_id_use_imm ? i_id_imm : fwd_b;
        o_alu_funct3 <= i_id_funct3;
        o_alu_funct7 <= i_id_funct7;
        o_alu_imm    <= i_id_use_imm;
        rd           <= i_id_rd;
      end
      // wb_data/rd outlive the handshake so later ops can still forward from them
      if (state == EXEC && !i_alu_busy) begin
        o_wb_data  <= i_alu_out;
        o_wb_rd    <= rd;
        o_wb_valid <= 1'b1;
        fwd_valid  <= 1'b1;
      end else if (state == DONE && i_wb_ready) begin
        o_wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage; the bench plays decode, ALU and writeback,
// and predicts operands/results from a last-result forwarding model.
module tb_alu_exec_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_ready, use_imm, alu_en, alu_imm, alu_busy, wb_valid, wb_ready;
  logic [RW-1:0]   rs1, rs2, rd, wb_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, alu_a, alu_b, alu_out, wb_data;
  logic [2:0]      f3, alu_f3;
  logic [6:0]      f7, alu_f7;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: newest result and its destination, and whether one exists
  logic            m_valid;
  logic [XLEN-1:0] m_data;
  logic [RW-1:0]   m_rd;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
    .i_clk_n(clk), .i_rst_n(rst_n),
    .i_id_valid(id_valid), .o_id_ready(id_ready),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_data(rs1_data), .i_id_rs2_data(rs2_data),
    .i_id_imm(imm), .i_id_use_imm(use_imm), .i_id_funct3(f3), .i_id_funct7(f7), .i_id_rd(rd),
    .o_alu_in_a(alu_a), .o_alu_in_b(alu_b), .o_alu_funct3(alu_f3), .o_alu_funct7(alu_f7),
    .o_alu_en(alu_en), .o_alu_imm(alu_imm), .i_alu_busy(alu_busy), .i_alu_out(alu_out),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_data(wb_data), .o_wb_rd(wb_rd)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] fn3, input logic [6:0] fn7);
    case (fn3)
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return fn7[5] ? a - b : a + b;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r, input logic [XLEN-1:0] d);
    return (m_valid && r == m_rd && r != 0) ? m_data : d;
  endfunction

  // One op: accept, nbusy busy cycles, one finishing cycle, then nstall cycles of wb backpressure.
  task automatic run_op(input logic [RW-1:0] a_r, input logic [RW-1:0] b_r,
                        input logic [XLEN-1:0] a_d, input logic [XLEN-1:0] b_d,
                        input logic [XLEN-1:0] im, input logic ui,
                        input logic [2:0] fn3, input logic [6:0] fn7, input logic [RW-1:0] d,
                        input int nbusy, input int nstall);
    logic [XLEN-1:0] ea, eb, res, held;
    ea  = fwd(a_r, a_d);
    eb  = ui ? im : fwd(b_r, b_d);
    res = alu_ref(ea, eb, fn3, fn7);
    rs1 = a_r; rs2 = b_r; rs1_data = a_d; rs2_data = b_d; imm = im; use_imm = ui;
    f3 = fn3; f7 = fn7; rd = d; id_valid = 1'b1; wb_ready = 1'b1; alu_busy = 1'b0;
    #1 chk("id_ready_at_accept", 32'(id_ready), 32'd1);
    tick();
    // decode keeps offering junk; none of it may be taken while executing
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; f3 = 3'($urandom); rd = RW'($urandom);
    for (int i = 0; i <= nbusy; i++) begin
      alu_busy = (i < nbusy);
      alu_out  = alu_busy ? $urandom : res;
      #1;
      chk("alu_en", 32'(alu_en), 32'd1);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_f3", 32'(alu_f3), 32'(fn3));
      chk("alu_f7", 32'(alu_f7), 32'(fn7));
      chk("alu_imm", 32'(alu_imm), 32'(ui));
      chk("id_ready_exec", 32'(id_ready), 32'd0);
      chk("wb_valid_exec", 32'(wb_valid), 32'd0);
      tick();
    end
    alu_busy = 1'b0;
    alu_out  = $urandom;
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_data", wb_data, res);
    chk("wb_rd", 32'(wb_rd), 32'(d));
    chk("alu_en_done", 32'(alu_en), 32'd0);
    m_valid = 1'b1; m_data = res; m_rd = d;
    held = wb_data;
    wb_ready = 1'b0;
    for (int i = 0; i < nstall; i++) begin
      #1 chk("id_ready_stall", 32'(id_ready), 32'd0);
      tick();
      chk("wb_hold_valid", 32'(wb_valid), 32'd1);
      chk("wb_hold_data", wb_data, held);
      chk("wb_hold_rd", 32'(wb_rd), 32'(d));
    end
  endtask

  task automatic drain();
    id_valid = 1'b0; wb_ready = 1'b1;
    tick();
    chk("drain_wb_valid", 32'(wb_valid), 32'd0);
    chk("drain_alu_en", 32'(alu_en), 32'd0);
    chk("drain_id_ready", 32'(id_ready), 32'd1);
    chk("drain_wb_data_kept", wb_data, m_data);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; wb_ready = 1'b1; alu_busy = 1'b0; alu_out = '0;
    rs1 = '0; rs2 = '0; rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0;
    f3 = '0; f7 = '0; rd = '0;
    m_valid = 1'b0; m_data = '0; m_rd = '0;
    tick(); tick();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    rst_n = 1'b1;

    // ADD 5+7 -> x3
    run_op(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 7'd0, 5'd3, 0, 0);
    drain();
    // x4 <= 0x10, then immediate op forwarding rs1=4
    run_op(5'd1, 5'd2, 32'h8, 32'h8, 32'd0, 1'b0, 3'd0, 7'd0, 5'd4, 0, 0);
    run_op(5'd4, 5'd0, 32'd0, 32'd0, 32'h20, 1'b1, 3'd0, 7'd0, 5'd5, 0, 0);
    drain();
    // result tagged x0 must not forward into rs1=0
    run_op(5'd1, 5'd2, 32'h3, 32'h4, 32'd0, 1'b0, 3'd6, 7'd0, 5'd0, 0, 0);
    run_op(5'd0, 5'd0, 32'h0, 32'h0, 32'h20, 1'b1, 3'd0, 7'd0, 5'd6, 0, 0);
    // busy stall, then backpressure with decode offering an op
    run_op(5'd6, 5'd6, 32'h1, 32'h2, 32'd0, 1'b0, 3'd7, 7'd0, 5'd7, 3, 4);
    // back-to-back dependent and independent ops
    run_op(5'd7, 5'd9, 32'h11, 32'h22, 32'd0, 1'b0, 3'd0, 7'h20, 5'd8, 0, 0);
    run_op(5'd10, 5'd8, 32'h33, 32'h44, 32'd0, 1'b0, 3'd4, 7'd0, 5'd9, 0, 0);
    run_op(5'd11, 5'd12, 32'h55, 32'h66, 32'd0, 1'b0, 3'd0, 7'd0, 5'd10, 0, 0);
    run_op(5'd10, 5'd10, 32'h77, 32'h88, 32'd0, 1'b0, 3'd0, 7'd0, 5'd11, 0, 0);
    drain();

    // random ops over a small register window so forwarding is hit often
    for (int n = 0; n < 40; n++) begin
      run_op(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             1'($urandom), 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
             RW'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    // reset mid-op while the ALU is busy
    run_op(5'd1, 5'd2, 32'h100, 32'h200, 32'd0, 1'b0, 3'd0, 7'd0, 5'd2, 0, 0);
    rs1 = 5'd2; rs2 = 5'd0; rs1_data = 32'h5; rs2_data = 32'h6; use_imm = 1'b0;
    f3 = 3'd0; f7 = 7'd0; rd = 5'd3; id_valid = 1'b1; wb_ready = 1'b1;
    tick();
    id_valid = 1'b0; alu_busy = 1'b1; alu_out = $urandom;
    #1 chk("pre_rst_alu_en", 32'(alu_en), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_alu_en", 32'(alu_en), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_id_ready", 32'(id_ready), 32'd1);
    chk("midrst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1; alu_busy = 1'b0;
    m_valid = 1'b0; m_data = '0; m_rd = '0;
    tick();
    chk("postrst_wb_valid", 32'(wb_valid), 32'd0);
    run_op(5'd0, 5'd0, 32'h9, 32'h1, 32'd0, 1'b0, 3'd0, 7'd0, 5'd0, 0, 0);
    run_op(5'd0, 5'd2, 32'h9, 32'h1, 32'd0, 1'b0, 3'd0, 7'd0, 5'd1, 1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage sequencer between decode and writeback.
- Latches one decoded ALU op, resolves forwarding, and selects operand B (register or immediate).
- Drives the ALU with stable inputs while the ALU reports busy (e.g. multi-cycle shifts, mul/div).
- Captures the result into a valid/ready writeback register.

Parameters:
- XLEN, 32, datapath width.
- REG_IDX_W, 5, register index width.

Ports:
- i_clk_n  in  1  stage clock; all registers update on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_id_valid  in  1  decode presents an op.
- o_id_ready  out  1  stage accepts the op this cycle.
- i_id_rs1  in  REG_IDX_W  source 1 index.
- i_id_rs2  in  REG_IDX_W  source 2 index.
- i_id_rs1_data  in  XLEN  regfile value for rs1.
- i_id_rs2_data  in  XLEN  regfile value for rs2.
- i_id_imm  in  XLEN  sign-extended immediate.
- i_id_use_imm  in  1  operand B = immediate.
- i_id_funct3  in  3  funct3 field.
- i_id_funct7  in  7  funct7 field.
- i_id_rd  in  REG_IDX_W  destination index.
- o_alu_in_a  out  XLEN  ALU operand A.
- o_alu_in_b  out  XLEN  ALU operand B.
- o_alu_funct3  out  3  to ALU.
- o_alu_funct7  out  7  to ALU.
- o_alu_en  out  1  ALU enable.
- o_alu_imm  out  1  immediate-form flag to ALU.
- i_alu_busy  in  1  ALU not finished.
- i_alu_out  in  XLEN  ALU result.
- o_wb_valid  out  1  result available.
- i_wb_ready  in  1  writeback accepts.
- o_wb_data  out  XLEN  result.
- o_wb_rd  out  REG_IDX_W  result destination.

Behaviour:
- Reset (i_rst_n=0 at a rising edge of i_clk_n):
  - state=IDLE.
  - All operand/func/rd registers = 0.
  - o_wb_valid=0, o_wb_data=0, o_wb_rd=0, fwd_valid=0.
  - o_alu_en=0.
  - Reset overrides every other event and aborts any in-flight op; no result is produced for it.
- FSM states:
  - IDLE: no op held.
  - EXEC: op latched, ALU driven.
  - DONE: result held in writeback register.
- o_id_ready = (state==IDLE) | (state==DONE & i_wb_ready). Combinational; must never be 1 in EXEC.
- Accept = i_id_valid & o_id_ready. On accept:
  - Latch A = fwd(rs1).
  - Latch B = i_id_use_imm ? i_id_imm : fwd(rs2).
  - Latch funct3, funct7, use_imm, rd.
  - Go to EXEC.
- Forwarding: fwd(rs) = o_wb_data if (fwd_valid & rs==o_wb_rd & rs!=0), else the regfile data. Index 0 is never forwarded.
- EXEC:
  - o_alu_en=1; ALU inputs come from latched registers only and are stable for the whole EXEC period.
  - If i_alu_busy=0: o_wb_data<=i_alu_out, o_wb_rd<=rd, o_wb_valid<=1, fwd_valid<=1, go to DONE.
  - Else stay in EXEC.
  - i_alu_busy is sampled only in EXEC.
- Outside EXEC: o_alu_en=0 (prevents the ALU's multi-cycle units from starting spuriously); o_alu_in_a/b keep their last values.
- DONE:
  - o_wb_valid=1; o_wb_data/o_wb_rd held stable until i_wb_ready=1.
  - Handshake with accept → EXEC (back-to-back).
  - Handshake without accept → IDLE, o_wb_valid<=0.
  - Handshake with no i_id_valid → IDLE.
- After a handshake, o_wb_data/o_wb_rd retain the last result and fwd_valid stays 1, so later ops forward the newest result.
- Latency:
  - Accept at edge N → EXEC in cycle N..N+1.
  - With i_alu_busy=0, o_wb_valid=1 after edge N+1.
  - Each busy cycle adds one cycle.
  - Peak throughput is one op per 2 cycles.
- i_wb_ready low in DONE: no new op is accepted; decode sees o_id_ready=0.
- Width: all data XLEN; no arithmetic inside the block beyond muxing; index compare over REG_IDX_W bits.

Test Plan:
- ADD: rs1_data=5, rs2_data=7, funct3=0, funct7=0, use_imm=0, rd=3, busy=0, wb_ready=1 → o_alu_in_a=5, o_alu_in_b=7 during EXEC; o_wb_valid=1 with o_wb_data=12, o_wb_rd=3 two edges after accept.
- Immediate plus forwarding:
  - Op1 writes rd=4 result 0x10.
  - Op2 uses rs1=4, regfile data 0, imm=0x20, use_imm=1.
  - Required: o_alu_in_a=0x10, o_alu_in_b=0x20, o_alu_imm=1.
  - Repeat with rd=0/rs1=0 → regfile data used.
- Busy stall: hold i_alu_busy=1 for 3 EXEC cycles → o_alu_in_a/b/funct are unchanged and o_id_ready=0 throughout; o_wb_valid rises exactly after the first busy=0 cycle; o_wb_data equals i_alu_out from that cycle.
- Backpressure: i_wb_ready=0 for 4 cycles in DONE with i_id_valid=1 → o_wb_data stable, o_id_ready=0, no accept; on i_wb_ready=1 the new op is accepted in the same cycle and the state goes to EXEC.
- Back-to-back: 4 independent ops, i_id_valid and i_wb_ready held at 1, busy=0 → results appear in order, one every 2 cycles, no drops or duplicates.
- Reset mid-op: assert i_rst_n=0 during EXEC with busy=1 → after the edge o_alu_en=0, o_wb_valid=0, o_id_ready=1, o_wb_data=0; the next op does not forward stale data (fwd_valid=0).
